// File: rtl/except_arbiter_nway_pkg.sv
// Shared cpu_defs: exception vector layout, CP0 view, redirect request
// and MIPS exception codes/vector offsets for the commit-stage arbiter.
package cpu_defs;

   localparam int NUM_LANES = 2;
   localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   // MSB first: iaddr_illegal is the top bit of each lane slice
   typedef struct packed {
      logic iaddr_illegal;
      logic iaddr_miss;
      logic iaddr_invalid;
      logic syscall;
      logic brk;
      logic overflow;
      logic trap;
      logic fpe;
      logic eret;
      logic priv_inst;
      logic invalid_inst;
      logic daddr_unaligned;
      logic daddr_illegal;
      logic daddr_miss;
      logic daddr_invalid;
      logic daddr_readonly;
   } ExceptVec_t;

   localparam int EXC_VEC_W = $bits(ExceptVec_t);

   typedef struct packed {
      logic        ie;
      logic        exl;
      logic        erl;
      logic        bev;
      logic        iv;
      logic [19:0] ebase;
      logic [31:0] epc;
      logic [31:0] error_epc;
      logic        user_mode;
   } CP0View_t;

   typedef struct packed {
      logic [4:0]        code;
      logic              eret;
      logic [31:0]       cur_pc;
      logic              delayslot;
      logic [31:0]       extra;
      logic [31:0]       jump_pc;
      logic [LANE_W-1:0] lane;
   } ExceptReq_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REDIRECT,
      ST_MASK
   } arb_state_e;

   localparam logic [4:0] EXCCODE_INT  = 5'd0;
   localparam logic [4:0] EXCCODE_MOD  = 5'd1;
   localparam logic [4:0] EXCCODE_TLBL = 5'd2;
   localparam logic [4:0] EXCCODE_TLBS = 5'd3;
   localparam logic [4:0] EXCCODE_ADEL = 5'd4;
   localparam logic [4:0] EXCCODE_ADES = 5'd5;
   localparam logic [4:0] EXCCODE_SYS  = 5'd8;
   localparam logic [4:0] EXCCODE_BP   = 5'd9;
   localparam logic [4:0] EXCCODE_RI   = 5'd10;
   localparam logic [4:0] EXCCODE_CPU  = 5'd11;
   localparam logic [4:0] EXCCODE_OV   = 5'd12;
   localparam logic [4:0] EXCCODE_TR   = 5'd13;
   localparam logic [4:0] EXCCODE_FPE  = 5'd15;

   localparam logic [31:0] BOOT_VEC    = 32'hBFC0_0200;
   localparam logic [11:0] OFS_REFILL  = 12'h000;
   localparam logic [11:0] OFS_GENERAL = 12'h180;
   localparam logic [11:0] OFS_INT     = 12'h200;

   function automatic logic [31:0] vec_target(
      input logic        bev,
      input logic        exl,
      input logic        iv,
      input logic [19:0] ebase,
      input logic [4:0]  code
   );
      logic [11:0] ofs;
      if ((code == EXCCODE_TLBL || code == EXCCODE_TLBS) && !exl)
         ofs = OFS_REFILL;
      else if (code == EXCCODE_INT && iv && !exl)
         ofs = OFS_INT;
      else
         ofs = OFS_GENERAL;
      return bev ? (BOOT_VEC + {20'h0, ofs}) : {ebase, ofs};
   endfunction

endpackage

// File: rtl/except_arbiter_nway_lane_decode.sv
// Per-lane cause encoder: collapses one ExceptVec_t into the
// highest-priority cause code, eret flag and extra word.
module except_lane_decode
   import cpu_defs::*;
(
   input  ExceptVec_t  exc,
   input  logic [31:0] pc,
   input  logic [31:0] daddr,
   input  logic        mem_we,
   input  logic        user_mode,
   output logic        hit,
   output logic [4:0]  code,
   output logic        eret,
   output logic [31:0] extra
);

   logic priv;

   assign priv = exc.priv_inst & user_mode;

   always_comb begin
      hit   = 1'b1;
      code  = '0;
      eret  = 1'b0;
      extra = '0;
      priority case (1'b1)
         exc.iaddr_illegal: begin
            code  = EXCCODE_ADEL;
            extra = pc;
         end
         exc.iaddr_miss, exc.iaddr_invalid: begin
            code  = EXCCODE_TLBL;
            extra = pc;
         end
         exc.syscall:  code = EXCCODE_SYS;
         exc.brk:      code = EXCCODE_BP;
         exc.overflow: code = EXCCODE_OV;
         exc.trap:     code = EXCCODE_TR;
         exc.fpe:      code = EXCCODE_FPE;
         exc.eret:     eret = 1'b1;
         priv: begin
            code  = EXCCODE_CPU;
            extra = 32'd1;
         end
         exc.invalid_inst: code = EXCCODE_RI;
         exc.daddr_unaligned, exc.daddr_illegal: begin
            code  = mem_we ? EXCCODE_ADES : EXCCODE_ADEL;
            extra = daddr;
         end
         exc.daddr_miss, exc.daddr_invalid: begin
            code  = mem_we ? EXCCODE_TLBS : EXCCODE_TLBL;
            extra = daddr;
         end
         exc.daddr_readonly: begin
            code  = EXCCODE_MOD;
            extra = daddr;
         end
         default: hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/except_arbiter_nway.sv
// Precise-exception arbiter at the commit boundary with redirect handshake.
// EXCEPT_ARB_COUNTER_EN adds exc_count/irq_count redirect counters.
module except_arbiter_nway
   import cpu_defs::*;
#(
   parameter int LANES           = NUM_LANES,
   parameter int IRQ_WIDTH       = 8,
   parameter int IRQ_SYNC_STAGES = 2,
   parameter int IRQ_MASK_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [LANES-1:0]           lane_valid,
   input  logic [LANES*EXC_VEC_W-1:0] lane_except,
   input  logic [LANES*32-1:0]        lane_pc,
   input  logic [LANES-1:0]           lane_delayslot,
   input  logic [LANES*32-1:0]        lane_daddr,
   input  logic [LANES-1:0]           lane_mem_we,
   input  logic [IRQ_WIDTH-1:0]       irq_raw,
   input  CP0View_t                   cp0_in,
   input  logic                       redirect_ready,
   output logic                       flush,
   output logic                       req_valid,
   output ExceptReq_t                 req,
   output logic                       busy
`ifdef EXCEPT_ARB_COUNTER_EN
   ,
   output logic [31:0]                exc_count,
   output logic [31:0]                irq_count
`endif
);

   localparam int MASK_W = (IRQ_MASK_CYCLES > 0) ?
                           $clog2(IRQ_MASK_CYCLES + 1) : 1;

   logic [IRQ_SYNC_STAGES-1:0][IRQ_WIDTH-1:0] sync_q, sync_d;
   logic [IRQ_WIDTH-1:0] irq_sync;

   logic [LANES-1:0]       dec_hit;
   logic [LANES-1:0][4:0]  dec_code;
   logic [LANES-1:0]       dec_eret;
   logic [LANES-1:0][31:0] dec_extra;

   arb_state_e  state_q, state_d;
   ExceptReq_t  req_q, req_d;
   logic        req_valid_q, req_valid_d;
   logic        flush_q, flush_d;
   logic        busy_q, busy_d;
   logic [MASK_W-1:0] mask_cnt_q, mask_cnt_d;

   logic        irq_take;
   logic        sel_hit;
   logic        sel_ok;
   ExceptReq_t  sel_req;
   logic        accept;

   always_comb begin
      sync_d[0] = irq_raw;
      for (int s = 1; s < IRQ_SYNC_STAGES; s++)
         sync_d[s] = sync_q[s-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sync_q <= '0;
      else
         sync_q <= sync_d;
   end

   assign irq_sync = sync_q[IRQ_SYNC_STAGES-1];

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      ExceptVec_t exc_v;
      assign exc_v = lane_except[i*EXC_VEC_W +: EXC_VEC_W];
      except_lane_decode u_dec (
         .exc       (exc_v),
         .pc        (lane_pc[i*32 +: 32]),
         .daddr     (lane_daddr[i*32 +: 32]),
         .mem_we    (lane_mem_we[i]),
         .user_mode (cp0_in.user_mode),
         .hit       (dec_hit[i]),
         .code      (dec_code[i]),
         .eret      (dec_eret[i]),
         .extra     (dec_extra[i])
      );
   end

   assign irq_take = cp0_in.ie & ~cp0_in.exl & ~cp0_in.erl &
                     (|irq_sync) & (mask_cnt_q == '0) &
                     (state_q == ST_IDLE);

   // Scan youngest to oldest so the oldest excepting lane lands last
   always_comb begin
      sel_hit = 1'b0;
      sel_req = '0;
      if (irq_take) begin
         sel_hit           = 1'b1;
         sel_req.code      = EXCCODE_INT;
         sel_req.extra     = 32'(irq_sync);
         sel_req.cur_pc    = lane_pc[31:0];
         sel_req.delayslot = lane_delayslot[0];
      end else begin
         for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_valid[i] && dec_hit[i]) begin
               sel_hit           = 1'b1;
               sel_req.code      = dec_code[i];
               sel_req.eret      = dec_eret[i];
               sel_req.extra     = dec_extra[i];
               sel_req.cur_pc    = lane_pc[i*32 +: 32];
               sel_req.delayslot = lane_delayslot[i];
               sel_req.lane      = LANE_W'(i);
            end
         end
      end
      if (sel_req.eret)
         sel_req.jump_pc = cp0_in.erl ? cp0_in.error_epc : cp0_in.epc;
      else
         sel_req.jump_pc = vec_target(cp0_in.bev, cp0_in.exl, cp0_in.iv,
                                      cp0_in.ebase, sel_req.code);
      sel_ok = sel_hit &&
               (state_q == ST_IDLE || state_q == ST_MASK);
   end

   assign accept = (state_q == ST_REDIRECT) && redirect_ready;

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      req_valid_d = req_valid_q;
      flush_d     = flush_q;
      busy_d      = busy_q;
      mask_cnt_d  = mask_cnt_q;
      unique case (state_q)
         ST_IDLE, ST_MASK: begin
            if (state_q == ST_MASK) begin
               if (mask_cnt_q <= MASK_W'(1)) begin
                  state_d    = ST_IDLE;
                  mask_cnt_d = '0;
               end else begin
                  mask_cnt_d = mask_cnt_q - 1'b1;
               end
            end
            if (sel_ok) begin
               state_d     = ST_REDIRECT;
               req_d       = sel_req;
               req_valid_d = 1'b1;
               flush_d     = 1'b1;
               busy_d      = 1'b1;
               mask_cnt_d  = '0;
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready) begin
               req_d       = '0;
               req_valid_d = 1'b0;
               flush_d     = 1'b0;
               busy_d      = 1'b0;
               if (IRQ_MASK_CYCLES == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_MASK;
                  mask_cnt_d = MASK_W'(IRQ_MASK_CYCLES);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         req_valid_q <= 1'b0;
         flush_q     <= 1'b0;
         busy_q      <= 1'b0;
         mask_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         req_valid_q <= req_valid_d;
         flush_q     <= flush_d;
         busy_q      <= busy_d;
         mask_cnt_q  <= mask_cnt_d;
      end
   end

   assign flush     = flush_q;
   assign req_valid = req_valid_q;
   assign req       = req_q;
   assign busy      = busy_q;

`ifdef EXCEPT_ARB_COUNTER_EN
   logic [31:0] exc_cnt_q, exc_cnt_d;
   logic [31:0] irq_cnt_q, irq_cnt_d;
   logic        is_int;

   assign is_int = (req_q.code == EXCCODE_INT) && !req_q.eret;

   always_comb begin
      exc_cnt_d = exc_cnt_q;
      irq_cnt_d = irq_cnt_q;
      if (accept && is_int)
         irq_cnt_d = irq_cnt_q + 32'd1;
      else if (accept)
         exc_cnt_d = exc_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_cnt_q <= '0;
         irq_cnt_q <= '0;
      end else begin
         exc_cnt_q <= exc_cnt_d;
         irq_cnt_q <= irq_cnt_d;
      end
   end

   assign exc_count = exc_cnt_q;
   assign irq_count = irq_cnt_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_except_arbiter_nway.sv
// Directed bench for except_arbiter_nway: lane priority, IRQ sync and
// masking, handshake stall, ERET targets and async reset.
module tb_except_arbiter_nway;
   import cpu_defs::*;

   localparam int LANES = 2;

   logic                       clk;
   logic                       rst_n;
   logic [LANES-1:0]           lane_valid;
   logic [LANES*EXC_VEC_W-1:0] lane_except;
   logic [LANES*32-1:0]        lane_pc;
   logic [LANES-1:0]           lane_delayslot;
   logic [LANES*32-1:0]        lane_daddr;
   logic [LANES-1:0]           lane_mem_we;
   logic [7:0]                 irq_raw;
   CP0View_t                   cp0;
   logic                       redirect_ready;
   logic                       flush;
   logic                       req_valid;
   ExceptReq_t                 req;
   logic                       busy;
`ifdef EXCEPT_ARB_COUNTER_EN
   logic [31:0]                exc_count;
   logic [31:0]                irq_count;
`endif

   ExceptVec_t  ev0, ev1;
   logic [31:0] pc0, pc1, da0, da1;
   int          checks = 0;
   int          errors = 0;

   assign lane_except = {ev1, ev0};
   assign lane_pc     = {pc1, pc0};
   assign lane_daddr  = {da1, da0};

   except_arbiter_nway #(
      .LANES           (LANES),
      .IRQ_WIDTH       (8),
      .IRQ_SYNC_STAGES (2),
      .IRQ_MASK_CYCLES (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .lane_valid     (lane_valid),
      .lane_except    (lane_except),
      .lane_pc        (lane_pc),
      .lane_delayslot (lane_delayslot),
      .lane_daddr     (lane_daddr),
      .lane_mem_we    (lane_mem_we),
      .irq_raw        (irq_raw),
      .cp0_in         (cp0),
      .redirect_ready (redirect_ready),
      .flush          (flush),
      .req_valid      (req_valid),
      .req            (req),
      .busy           (busy)
`ifdef EXCEPT_ARB_COUNTER_EN
      ,
      .exc_count      (exc_count),
      .irq_count      (irq_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      lane_valid     = '0;
      lane_delayslot = '0;
      lane_mem_we    = '0;
      ev0 = '0; ev1 = '0;
      pc0 = '0; pc1 = '0; da0 = '0; da1 = '0;
      irq_raw        = '0;
      cp0            = '0;
      redirect_ready = 1'b0;
      tick; tick;
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req_code", 32'(req.code), 32'd0);
      rst_n = 1'b1;
      tick;
      check("idle_req_valid", 32'(req_valid), 32'd0);

      // Oldest lane wins even with a lower-priority cause
      cp0.ebase  = 20'h80000;
      pc0        = 32'h8000_1000;
      pc1        = 32'h8000_1004;
      ev0.overflow = 1'b1;
      ev1.syscall  = 1'b1;
      lane_valid = 2'b11;
      tick;
      check("t1_req_valid", 32'(req_valid), 32'd1);
      check("t1_flush", 32'(flush), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_code", 32'(req.code), 32'(EXCCODE_OV));
      check("t1_cur_pc", req.cur_pc, 32'h8000_1000);
      check("t1_jump", req.jump_pc, 32'h8000_0180);
      check("t1_lane", 32'(req.lane), 32'd0);
      lane_valid = '0;
      ev0 = '0; ev1 = '0;
      redirect_ready = 1'b1;
      tick;
      check("t1_accept_valid", 32'(req_valid), 32'd0);
      check("t1_accept_busy", 32'(busy), 32'd0);
      redirect_ready = 1'b0;
      tick; tick;

      // Interrupt through the two-stage synchroniser
      cp0.ie  = 1'b1;
      cp0.iv  = 1'b1;
      cp0.bev = 1'b1;
      irq_raw = 8'h08;
      tick;
      irq_raw = 8'h00;
      check("t2_sync1", 32'(req_valid), 32'd0);
      tick;
      check("t2_sync2", 32'(req_valid), 32'd0);
      tick;
      check("t2_req_valid", 32'(req_valid), 32'd1);
      check("t2_code", 32'(req.code), 32'(EXCCODE_INT));
      check("t2_extra", req.extra, 32'h0000_0008);
      check("t2_jump", req.jump_pc, 32'hBFC0_0400);
      check("t2_eret", 32'(req.eret), 32'd0);
      redirect_ready = 1'b1;
      cp0.ie = 1'b0;
      tick;
      redirect_ready = 1'b0;
      tick; tick;

      // Store TLB miss on lane 1, then stall the handshake
      cp0.bev = 1'b0;
      cp0.iv  = 1'b0;
      ev1.daddr_miss = 1'b1;
      lane_mem_we    = 2'b10;
      da1            = 32'h1234_5678;
      pc1            = 32'h8000_2004;
      lane_delayslot = 2'b10;
      lane_valid     = 2'b10;
      tick;
      check("t3_code", 32'(req.code), 32'(EXCCODE_TLBS));
      check("t3_extra", req.extra, 32'h1234_5678);
      check("t3_jump", req.jump_pc, 32'h8000_0000);
      check("t3_lane", 32'(req.lane), 32'd1);
      check("t3_delayslot", 32'(req.delayslot), 32'd1);
      ev1 = '0;
      ev0.syscall = 1'b1;
      lane_valid  = 2'b11;
      for (int k = 0; k < 5; k++) begin
         tick;
         check("t3_stall_valid", 32'(req_valid), 32'd1);
         check("t3_stall_busy", 32'(busy), 32'd1);
         check("t3_stall_code", 32'(req.code), 32'(EXCCODE_TLBS));
         check("t3_stall_extra", req.extra, 32'h1234_5678);
      end
`ifdef EXCEPT_ARB_COUNTER_EN
      check("t3_exc_count_stall", exc_count, 32'd1);
      check("t3_irq_count_stall", irq_count, 32'd1);
`endif
      lane_valid = '0;
      ev0 = '0;
      lane_delayslot = '0;
      lane_mem_we    = '0;
      redirect_ready = 1'b1;
      tick;
      check("t3_accept_valid", 32'(req_valid), 32'd0);
      check("t3_accept_flush", 32'(flush), 32'd0);
`ifdef EXCEPT_ARB_COUNTER_EN
      check("t3_exc_count_acc", exc_count, 32'd2);
`endif
      redirect_ready = 1'b0;
      tick; tick;

      // ERET with erl set, ready already high: 1-cycle redirect
      cp0.erl       = 1'b1;
      cp0.error_epc = 32'hBFC0_0010;
      cp0.epc       = 32'h8000_0100;
      pc0           = 32'h8000_3000;
      ev0.eret      = 1'b1;
      lane_valid    = 2'b01;
      redirect_ready = 1'b1;
      tick;
      check("t4_req_valid", 32'(req_valid), 32'd1);
      check("t4_eret", 32'(req.eret), 32'd1);
      check("t4_jump", req.jump_pc, 32'hBFC0_0010);
      lane_valid = '0;
      ev0 = '0;
      tick;
      check("t4_one_cycle", 32'(req_valid), 32'd0);
      redirect_ready = 1'b0;
      cp0.erl = 1'b0;
      tick; tick;

      // priv_inst counts only in user mode
      ev0.priv_inst = 1'b1;
      lane_valid    = 2'b01;
      tick;
      check("t4b_priv_kernel", 32'(req_valid), 32'd0);
      cp0.user_mode = 1'b1;
      tick;
      check("t4b_priv_user", 32'(req_valid), 32'd1);
      check("t4b_code", 32'(req.code), 32'(EXCCODE_CPU));
      check("t4b_extra", req.extra, 32'd1);
      ev0 = '0;
      lane_valid = '0;
      cp0.user_mode = 1'b0;
      redirect_ready = 1'b1;
      tick;
      redirect_ready = 1'b0;
      tick; tick;

      // Interrupt waits out the mask window after a redirect
      ev0.invalid_inst = 1'b1;
      lane_valid = 2'b01;
      tick;
      check("t5_ri_valid", 32'(req_valid), 32'd1);
      check("t5_ri_code", 32'(req.code), 32'(EXCCODE_RI));
      ev0 = '0;
      lane_valid = '0;
      cp0.ie  = 1'b1;
      irq_raw = 8'h01;
      tick; tick;
      check("t5_hold_redirect", 32'(req_valid), 32'd1);
      check("t5_hold_code", 32'(req.code), 32'(EXCCODE_RI));
      redirect_ready = 1'b1;
      tick;
      redirect_ready = 1'b0;
      check("t5_mask1", 32'(req_valid), 32'd0);
      tick;
      check("t5_mask2", 32'(req_valid), 32'd0);
      tick;
      check("t5_mask_idle", 32'(req_valid), 32'd0);
      tick;
      check("t5_int_valid", 32'(req_valid), 32'd1);
      check("t5_int_code", 32'(req.code), 32'(EXCCODE_INT));
      check("t5_int_extra", req.extra, 32'h0000_0001);
      check("t5_int_jump", req.jump_pc, 32'h8000_0180);
      irq_raw = 8'h00;
      cp0.ie  = 1'b0;
      redirect_ready = 1'b1;
      tick;
      redirect_ready = 1'b0;
      ev0.invalid_inst = 1'b1;
      lane_valid = 2'b01;
      tick;
      check("t5_ri_in_mask", 32'(req_valid), 32'd1);
      check("t5_ri_in_mask_code", 32'(req.code), 32'(EXCCODE_RI));

      // Asynchronous reset drops a pending redirect
      ev0 = '0;
      lane_valid = '0;
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(req_valid), 32'd0);
      check("t6_rst_flush", 32'(flush), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_code", 32'(req.code), 32'd0);
`ifdef EXCEPT_ARB_COUNTER_EN
      check("t6_rst_exc_count", exc_count, 32'd0);
`endif
      tick;
      rst_n = 1'b1;
      tick;
      check("t6_post_valid", 32'(req_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
